toggle_handshake_receiver: RTL



---
 rtl/toggle_handshake_receiver.sv | 89 ++++++++
 1 files changed

// File: rtl/toggle_handshake_receiver.sv
// Receiving end of a two-phase toggle link: detects each request flip, buffers
// the word in a small FIFO, returns a toggle ack and flags double-toggle errors.
module toggle_handshake_receiver #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        rx_count,
    output logic              proto_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              req_q;

    logic              pending_c;
    logic              full_c;
    logic              accept_c;
    logic              pop_c;
    logic              violation_c;
    logic [CW-1:0]     count_next_c;

    // Handshake decode and occupancy update; full blocks accept even when a pop
    // happens in the same cycle, so there is no bypass path.
    always_comb begin
        pending_c    = req_tgl ^ ack_tgl;
        full_c       = (count == CW'(DEPTH));
        accept_c     = pending_c & ~full_c;
        pop_c        = out_valid & out_ready;
        // Sender flipped again while its previous flip is still unacknowledged.
        violation_c  = (req_tgl != req_q) & (req_q != ack_tgl);
        count_next_c = count;
        case ({accept_c, pop_c})
            2'b10:   count_next_c = count + CW'(1);
            2'b01:   count_next_c = count - CW'(1);
            default: count_next_c = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            ack_tgl   <= 1'b0;
            rx_count  <= 8'd0;
            proto_err <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            if (accept_c) begin
                wr_ptr   <= wr_ptr + AW'(1);
                ack_tgl  <= ~ack_tgl;
                rx_count <= rx_count + 8'd1;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (violation_c) begin
                proto_err <= 1'b1;
            end
            count     <= count_next_c;
            out_valid <= (count_next_c != '0);
            req_q     <= req_tgl;
        end
    end

    // Storage is not cleared by reset; only the pointers are.
    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign out_data = mem[rd_ptr];

endmodule
